// File: rtl/frame_point_reader.sv
// frame_point_reader: walks the active ping-pong display-list buffer and
// presents one point at a time to the DAC driver over valid/ready.
// Buffer swaps requested by the host are deferred to the next frame boundary.
module frame_point_reader #(
   parameter logic [31:0] BUF0_BASE   = 32'h0000_0000,
   parameter logic [31:0] BUF1_BASE   = 32'h0000_0400,
   parameter int unsigned MAX_POINTS  = 255,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        swap_req,
   output logic        swap_ack,
   output logic [31:0] client_addr,
   output logic [31:0] client_din,
   output logic        mwe_client,
   input  logic [31:0] client_dout,
   output logic [11:0] point_x,
   output logic [11:0] point_y,
   output logic        laser_on,
   output logic        point_valid,
   input  logic        point_ready,
   output logic        frame_start,
   output logic [15:0] frame_count,
   output logic        active_buf
);

   typedef enum logic [2:0] {
      IDLE,
      RD_HDR,
      RD_PT,
      PRESENT,
      END_FRAME
   } state_t;

   localparam logic [15:0] MAX_N = 16'(MAX_POINTS);
   localparam logic [1:0]  LAT   = 2'(MEM_LATENCY);

   state_t      state_q, state_d;
   logic [1:0]  wait_q, wait_d;
   logic [15:0] n_q, n_d;
   logic [15:0] k_q, k_d;
   logic        pending_q, pending_d;
   logic        active_q, active_d;
   logic        swap_ack_q, swap_ack_d;
   logic [31:0] addr_q, addr_d;
   logic [11:0] px_q, px_d;
   logic [11:0] py_q, py_d;
   logic        laser_q, laser_d;
   logic        valid_q, valid_d;
   logic        fs_q, fs_d;
   logic [15:0] fc_q, fc_d;

   logic [31:0] base_cur;
   logic [15:0] hdr_n;
   logic [15:0] k_next;
   logic        unused_dout_bits;

   assign base_cur         = active_q ? BUF1_BASE : BUF0_BASE;
   assign hdr_n            = (client_dout[15:0] > MAX_N) ? MAX_N : client_dout[15:0];
   assign k_next           = k_q + 16'd1;
   assign unused_dout_bits = ^client_dout[31:25];

   // Next-state and next-output computation for the frame walker.
   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      n_d        = n_q;
      k_d        = k_q;
      pending_d  = pending_q | swap_req;
      active_d   = active_q;
      swap_ack_d = 1'b0;
      addr_d     = addr_q;
      px_d       = px_q;
      py_d       = py_q;
      laser_d    = laser_q;
      valid_d    = valid_q;
      fs_d       = 1'b0;
      fc_d       = fc_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = RD_HDR;
               addr_d  = base_cur;
               wait_d  = '0;
            end
         end
         RD_HDR: begin
            if (wait_q == LAT) begin
               n_d  = hdr_n;
               k_d  = '0;
               fs_d = 1'b1;
               if (hdr_n == 16'd0) begin
                  state_d = END_FRAME;
               end else begin
                  state_d = RD_PT;
                  addr_d  = base_cur + 32'd4;
                  wait_d  = '0;
               end
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         RD_PT: begin
            if (wait_q == LAT) begin
               px_d    = client_dout[11:0];
               py_d    = client_dout[23:12];
               laser_d = client_dout[24];
               valid_d = 1'b1;
               state_d = PRESENT;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         PRESENT: begin
            if (point_ready) begin
               valid_d = 1'b0;
               laser_d = 1'b0;
               if (k_next < n_q) begin
                  k_d     = k_next;
                  addr_d  = base_cur + 32'd4 + {14'd0, k_next, 2'b00};
                  wait_d  = '0;
                  state_d = RD_PT;
               end else begin
                  state_d = END_FRAME;
               end
            end
         end
         END_FRAME: begin
            fc_d = fc_q + 16'd1;
            // A request arriving on this very cycle is folded into this boundary.
            if (pending_q | swap_req) begin
               active_d   = ~active_q;
               swap_ack_d = 1'b1;
               pending_d  = 1'b0;
            end
            if (enable) begin
               state_d = RD_HDR;
               addr_d  = active_d ? BUF1_BASE : BUF0_BASE;
               wait_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs, cleared asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wait_q     <= '0;
         n_q        <= '0;
         k_q        <= '0;
         pending_q  <= 1'b0;
         active_q   <= 1'b0;
         swap_ack_q <= 1'b0;
         addr_q     <= BUF0_BASE;
         px_q       <= '0;
         py_q       <= '0;
         laser_q    <= 1'b0;
         valid_q    <= 1'b0;
         fs_q       <= 1'b0;
         fc_q       <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         n_q        <= n_d;
         k_q        <= k_d;
         pending_q  <= pending_d;
         active_q   <= active_d;
         swap_ack_q <= swap_ack_d;
         addr_q     <= addr_d;
         px_q       <= px_d;
         py_q       <= py_d;
         laser_q    <= laser_d;
         valid_q    <= valid_d;
         fs_q       <= fs_d;
         fc_q       <= fc_d;
      end
   end

   assign swap_ack    = swap_ack_q;
   assign client_addr = addr_q;
   assign client_din  = '0;
   assign mwe_client  = 1'b0;
   assign point_x     = px_q;
   assign point_y     = py_q;
   assign laser_on    = laser_q;
   assign point_valid = valid_q;
   assign frame_start = fs_q;
   assign frame_count = fc_q;
   assign active_buf  = active_q;

endmodule

// File: tb/tb_frame_point_reader.sv
// Bench for frame_point_reader: memory model, frame-level reference model,
// directed scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_frame_point_reader;

   localparam int unsigned LAT  = 1;
   localparam int unsigned MAXP = 255;
   localparam logic [31:0] B0   = 32'h0000_0000;
   localparam logic [31:0] B1   = 32'h0000_0400;
   localparam logic [31:0] P0   = {7'd0, 1'b1, 12'd2, 12'd1};
   localparam logic [31:0] P1   = {7'd0, 1'b0, 12'd4, 12'd3};
   localparam logic [31:0] P2   = {7'd0, 1'b1, 12'd6, 12'd5};
   localparam logic [31:0] Q0   = {7'd0, 1'b1, 12'd8, 12'd7};
   localparam logic [31:0] Q1   = {7'd0, 1'b0, 12'd10, 12'd9};

   logic        clk = 1'b0;
   logic        rst_n, enable, swap_req, swap_ack;
   logic [31:0] client_addr, client_din, client_dout;
   logic        mwe_client;
   logic [11:0] point_x, point_y;
   logic        laser_on, point_valid, point_ready, frame_start, active_buf;
   logic [15:0] frame_count;

   always #5 clk = ~clk;

   frame_point_reader #(
      .BUF0_BASE  (B0),
      .BUF1_BASE  (B1),
      .MAX_POINTS (MAXP),
      .MEM_LATENCY(LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .swap_req   (swap_req),
      .swap_ack   (swap_ack),
      .client_addr(client_addr),
      .client_din (client_din),
      .mwe_client (mwe_client),
      .client_dout(client_dout),
      .point_x    (point_x),
      .point_y    (point_y),
      .laser_on   (laser_on),
      .point_valid(point_valid),
      .point_ready(point_ready),
      .frame_start(frame_start),
      .frame_count(frame_count),
      .active_buf (active_buf)
   );

   // memory_share stand-in: read data appears LAT cycles after the address
   logic [31:0] mem  [0:1023];
   logic [31:0] pipe [0:LAT-1];
   always @(posedge clk) begin
      pipe[0] <= mem[client_addr[11:2]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign client_dout = pipe[LAT-1];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] base_of(input logic b);
      return b ? B1 : B0;
   endfunction

   // reference model state
   logic [31:0] expq[$];
   logic [31:0] acc_log[$];
   logic        exp_buf, exp_pend, exp_ack, end_next, prev_hold, prev_valid, did_end;
   logic [15:0] exp_fc;
   logic [11:0] prev_x, prev_y;
   logic        prev_on;
   logic [31:0] prev_addr, last_acc_addr, w;
   int          cyc = 0, hdr_cyc = -1, last_acc_cyc = 0, done_in_frame = 0;
   int          acc_cnt = 0, fs_cnt = 0, ack_cnt = 0;

   task automatic model_reset();
      expq.delete();
      exp_buf = 1'b0; exp_pend = 1'b0; exp_ack = 1'b0; end_next = 1'b0;
      prev_hold = 1'b0; prev_valid = 1'b0; exp_fc = '0;
      prev_addr = B0; hdr_cyc = -1; done_in_frame = 0;
   endtask

   // frame boundary: count the frame, apply any swap, decide whether a header read follows
   task automatic end_frame();
      exp_fc = exp_fc + 16'd1;
      if (exp_pend || swap_req) begin
         exp_buf  = ~exp_buf;
         exp_pend = 1'b0;
         exp_ack  = 1'b1;
      end
      hdr_cyc = enable ? cyc + 1 : -1;
      did_end = 1'b1;
   endtask

   task automatic start_frame();
      int hidx, hdr, eff;
      hidx = int'(base_of(exp_buf) >> 2);
      hdr  = int'(mem[hidx][15:0]);
      eff  = (hdr > int'(MAXP)) ? int'(MAXP) : hdr;
      for (int k = 0; k < eff; k++) expq.push_back(mem[hidx + 1 + k]);
      done_in_frame = 0;
      if (eff == 0) end_frame();
   endtask

   initial model_reset();

   // compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      cyc++;
      did_end = 1'b0;
      if (!rst_n) begin
         chk("rst_valid", point_valid, 0);
         chk("rst_laser", laser_on, 0);
         chk("rst_fc", frame_count, 0);
         chk("rst_active", active_buf, 0);
         chk("rst_ack", swap_ack, 0);
         chk("rst_fs", frame_start, 0);
         chk("rst_addr", client_addr, B0);
         model_reset();
      end else begin
         if (swap_ack) ack_cnt++;
         chk("swap_ack", swap_ack, exp_ack);
         exp_ack = 1'b0;
         chk("active_buf", active_buf, exp_buf);
         chk("frame_count", frame_count, exp_fc);
         chk("client_din", client_din, 0);
         chk("mwe_client", mwe_client, 0);
         if (cyc == hdr_cyc) chk("hdr_addr", client_addr, base_of(exp_buf));
         if (!point_valid) chk("laser_idle", laser_on, 0);
         if (prev_hold) begin
            chk("hold_valid", point_valid, 1);
            chk("hold_x", point_x, prev_x);
            chk("hold_y", point_y, prev_y);
            chk("hold_on", laser_on, prev_on);
         end
         if (end_next) begin
            end_next = 1'b0;
            end_frame();
         end
         if (frame_start) begin
            fs_cnt++;
            chk("fs_midframe", expq.size(), 0);
            chk("hdr_read_addr", prev_addr, base_of(exp_buf));
            if (hdr_cyc >= 0) chk("hdr_latency", cyc - hdr_cyc, LAT + 1);
            start_frame();
         end
         if (point_valid) begin
            chk("pt_addr", client_addr, base_of(exp_buf) + 32'd4 + 32'(4 * done_in_frame));
            if (!prev_valid) begin
               if (done_in_frame == 0) begin
                  if (hdr_cyc >= 0) chk("first_pt_latency", cyc - hdr_cyc, 2 * LAT + 2);
               end else begin
                  chk("pt_gap", cyc - last_acc_cyc, LAT + 2);
               end
            end
            if (point_ready) begin
               acc_cnt++;
               chk("pt_expected", expq.size() > 0, 1);
               if (expq.size() > 0) begin
                  w = expq.pop_front();
                  chk("pt_x", point_x, w[11:0]);
                  chk("pt_y", point_y, w[23:12]);
                  chk("pt_on", laser_on, w[24]);
                  if (expq.size() == 0) end_next = 1'b1;
               end
               acc_log.push_back({7'd0, laser_on, point_y, point_x});
               last_acc_addr = client_addr;
               last_acc_cyc  = cyc;
               done_in_frame++;
            end
         end
         if (swap_req && !did_end) exp_pend = 1'b1;
         prev_hold  = point_valid && !point_ready;
         prev_x     = point_x;
         prev_y     = point_y;
         prev_on    = laser_on;
         prev_valid = point_valid;
         prev_addr  = client_addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; swap_req = 1'b0; point_ready = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      acc_log.delete();
      acc_cnt = 0; fs_cnt = 0; ack_cnt = 0;
   endtask

   task automatic load_basic();
      mem[0]   = 32'd3; mem[1] = P0; mem[2] = P1; mem[3] = P2;
      mem[256] = 32'd2; mem[257] = Q0; mem[258] = Q1;
   endtask

   task automatic wait_acc(input int target, input int budget, input string name);
      for (int i = 0; i < budget && acc_cnt < target; i++) tick();
      chk(name, acc_cnt, target);
   endtask

   task automatic wait_fs(input int target, input int budget, input string name);
      for (int i = 0; i < budget && fs_cnt < target; i++) tick();
      chk(name, fs_cnt, target);
   endtask

   task automatic wait_fc(input int target, input int budget, input string name);
      for (int i = 0; i < budget && int'(frame_count) < target; i++) tick();
      chk(name, frame_count, target);
   endtask

   task automatic pulse_swap();
      swap_req = 1'b1; tick(); swap_req = 1'b0;
   endtask

   initial begin
      // basic three-point frame, ready tied high
      do_reset();
      load_basic();
      rst_n = 1'b1; enable = 1'b1; point_ready = 1'b1;
      wait_acc(3, 60, "t1_timeout");
      chk("t1_p0", acc_log[0], P0);
      chk("t1_p1", acc_log[1], P1);
      chk("t1_p2", acc_log[2], P2);
      wait_fc(1, 20, "t1_fc");
      wait_fs(2, 20, "t1_reread");

      // back-pressure on point 1 of the second frame
      wait_acc(4, 60, "t2_timeout");
      point_ready = 1'b0;
      for (int i = 0; i < 20 && !point_valid; i++) tick();
      chk("t2_valid_rise", point_valid, 1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t2_x", point_x, 12'd3);
         chk("t2_y", point_y, 12'd4);
         chk("t2_v", point_valid, 1);
      end
      chk("t2_no_accept", acc_cnt, 4);
      point_ready = 1'b1;
      wait_acc(6, 60, "t2_resume");
      chk("t2_p1", acc_log[4], P1);

      // two swap pulses mid-frame -> one swap at the boundary
      wait_acc(7, 60, "t3_timeout");
      pulse_swap();
      tick();
      pulse_swap();
      wait_acc(11, 80, "t3_buf1");
      chk("t3_acks", ack_cnt, 1);
      chk("t3_active", active_buf, 1);
      chk("t3_q0", acc_log[9], Q0);
      chk("t3_q1", acc_log[10], Q1);
      chk("t3_last_addr", last_acc_addr, 32'h408);

      // empty frames loop on the header
      do_reset();
      rst_n = 1'b1; enable = 1'b1; point_ready = 1'b1;
      wait_fs(4, 60, "t4_timeout");
      chk("t4_fc", frame_count, 4);
      chk("t4_no_points", acc_cnt, 0);

      // oversized header clamps to MAX_POINTS
      do_reset();
      mem[0] = 32'd1000;
      for (int i = 1; i <= 255; i++) mem[i] = $urandom();
      rst_n = 1'b1; enable = 1'b1; point_ready = 1'b1;
      wait_fc(1, 2000, "t5_timeout");
      enable = 1'b0;
      chk("t5_count", acc_cnt, 255);
      chk("t5_last_addr", last_acc_addr, 32'h3FC);
      repeat (1000) begin
         if (point_valid || frame_start) tick();
      end

      // asynchronous reset while presenting
      do_reset();
      load_basic();
      rst_n = 1'b1; enable = 1'b1; point_ready = 1'b1;
      pulse_swap();
      wait_acc(4, 60, "t6_timeout");
      point_ready = 1'b0;
      for (int i = 0; i < 20 && !point_valid; i++) tick();
      chk("t6_present", point_valid, 1);
      chk("t6_active_pre", active_buf, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_valid", point_valid, 0);
      chk("t6_laser", laser_on, 0);
      chk("t6_fc", frame_count, 0);
      chk("t6_active", active_buf, 0);
      chk("t6_addr", client_addr, B0);
      tick(); tick();
      acc_log.delete(); acc_cnt = 0;
      rst_n = 1'b1; point_ready = 1'b1;
      wait_acc(1, 60, "t6_restart");
      chk("t6_first_pt", acc_log[0], P0);

      // randomized traffic against the model
      for (int it = 0; it < 6; it++) begin
         do_reset();
         mem[0]   = 32'($urandom_range(0, 6)) | ($urandom() & 32'hFFFF_0000);
         mem[256] = 32'($urandom_range(0, 6)) | ($urandom() & 32'hFFFF_0000);
         for (int i = 1; i <= 8; i++) begin
            mem[i]       = $urandom();
            mem[256 + i] = $urandom();
         end
         rst_n = 1'b1;
         for (int c = 0; c < 300; c++) begin
            enable      = ($urandom_range(0, 9) != 0);
            point_ready = ($urandom_range(0, 2) != 0);
            swap_req    = ($urandom_range(0, 12) == 0);
            if (c == 200 && it[0]) begin
               swap_req = 1'b0;
               rst_n    = 1'b0;
               tick(); tick();
               rst_n = 1'b1;
            end
            tick();
         end
         enable = 1'b0; swap_req = 1'b0; point_ready = 1'b1;
         repeat (40) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/frame_point_reader.md
Name: frame_point_reader

Overview:
- Read-side consumer of the client port of memory_share in the laser projector.
- The host writes display lists into two ping-pong buffers. This block walks the active buffer word by word and presents each point to the galvo/laser DAC driver over a valid/ready handshake.
- Buffer swaps are deferred to frame boundaries so a frame is never torn.

Parameters:
- BUF0_BASE, 32'h0000_0000, byte address of buffer 0 header word.
- BUF1_BASE, 32'h0000_0400, byte address of buffer 1 header word.
- MAX_POINTS, 255, header point counts above this are clamped to it.
- MEM_LATENCY, 1, cycles from client_addr presented to client_dout valid (range 1..3).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run frames when high
- swap_req  in  1  one-cycle pulse: switch buffers at next frame boundary
- swap_ack  out  1  one-cycle pulse when the swap takes effect
- client_addr  out  32  byte address to memory_share client port, always word-aligned
- client_din  out  32  constant 0
- mwe_client  out  1  constant 0; this block never writes
- client_dout  in  32  read data from memory_share
- point_x  out  12  X DAC code
- point_y  out  12  Y DAC code
- laser_on  out  1  beam enable for the presented point
- point_valid  out  1  point fields valid
- point_ready  in  1  DAC driver accepts the point
- frame_start  out  1  one-cycle pulse when a header is read
- frame_count  out  16  frames completed, wraps at 16'hFFFF -> 0
- active_buf  out  1  buffer currently being scanned

Behaviour:
- Reset values (applied immediately on rst_n low, also mid-operation):
  - all outputs 0; client_addr = BUF0_BASE; active_buf = 0
  - pending swap cleared; state IDLE
- Memory word formats:
  - header word: [15:0] = point count N; effective count = min(N, MAX_POINTS)
  - point word: [11:0] = x, [23:12] = y, [24] = laser_on; bits [31:25] ignored
  - point k (k = 0..N-1) sits at base + 4 + 4k
- States and transitions:
  - IDLE: if enable -> RD_HDR.
  - RD_HDR: drive client_addr = active base; wait MEM_LATENCY cycles; capture header; pulse frame_start.
    - effective N = 0 -> END_FRAME.
    - otherwise k = 0 -> RD_PT.
  - RD_PT: drive client_addr = base + 4 + 4k; wait MEM_LATENCY cycles; register the word into point_x / point_y / laser_on; assert point_valid on the cycle after capture -> PRESENT.
  - PRESENT: point fields and point_valid held stable until point_ready.
    - Accept is the cycle where point_valid and point_ready are both high.
    - On accept: point_valid drops the next cycle; laser_on returns to 0.
    - Then k + 1 < N -> RD_PT; otherwise -> END_FRAME.
  - END_FRAME: frame_count increments.
    - If a swap is pending: toggle active_buf, pulse swap_ack, clear pending.
    - Then enable -> RD_HDR; else -> IDLE.
- Latency: header address issued to first point_valid = 2 * MEM_LATENCY + 2 cycles.
- Throughput: one point per (MEM_LATENCY + 2) cycles when point_ready is held high.
- Swap requests:
  - A swap_req pulse in any state sets pending.
  - Several pulses before a boundary produce exactly one swap.
  - swap_req arriving on the END_FRAME cycle itself is applied at that boundary.
- enable deassert mid-frame: the current frame completes; stop at END_FRAME.
- Outside PRESENT, point_valid = 0 and laser_on = 0; the beam is never left on between points.
- client_addr is held at its last value while waiting or presenting.
- Empty frame (N = 0): no point_valid; frame_start, frame_count and swap still occur; loop re-reads the header every 2 + MEM_LATENCY cycles.

Test Plan:
- Buf0 header = 3, points {x=1,y=2,on}, {x=3,y=4,off}, {x=5,y=6,on}, point_ready tied 1, enable 1 -> three accepts in order with matching x/y/laser_on; frame_count increments after the third; header re-read at addr 0.
- Same list, point_ready held low 20 cycles on point 1 -> point_x = 3, point_y = 4, point_valid stay stable for all 20 cycles; exactly one accept.
- Buf1 header = 2; swap_req pulsed mid-frame 0 twice -> one swap_ack after the last point of the current frame; active_buf = 1; next client_addr = 32'h400; points read from 32'h404 and 32'h408.
- Header = 0 with enable 1 -> frame_start pulses repeat; point_valid never rises; frame_count increments each loop.
- Header = 1000 -> exactly 255 points presented; last address = base + 4*255.
- rst_n low during PRESENT -> point_valid, laser_on and frame_count read 0 immediately; active_buf = 0; after release, first header read at BUF0_BASE.
